// File: rtl/event_encoder_4to2_if.sv
// Output handshake bundle for event_encoder_4to2.
// Ports: out_code (event index), out_valid (code is valid), out_ready (consumer accepts).
interface event_encoder_4to2_if;
    logic [1:0] out_code;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_code,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_code,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/event_encoder_4to2.sv
// Rising-edge event latch plus priority encoder behind a valid/ready handshake.
// Ports: clk, reset (sync, high), in[3:0] event lines, bus (code/valid/ready),
//        pending_o (pending-event register), overrun (sticky lost-event flag).
module event_encoder_4to2 #(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  in,
    event_encoder_4to2_if.master        bus,
    output logic [3:0]                  pending_o,
    output logic                        overrun
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t     state, state_n;
    logic [3:0] in_q;
    logic [3:0] pending, pending_n;
    logic [3:0] rise, clr, rem;
    logic [1:0] code_q, code_n;
    logic       take;

    // Highest-priority set bit; later loop iterations override earlier ones.
    function automatic logic [1:0] pick(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        if (LSB_FIRST) begin
            for (int i = 3; i >= 0; i--)
                if (v[i]) r = i[1:0];
        end else begin
            for (int i = 0; i < 4; i++)
                if (v[i]) r = i[1:0];
        end
        return r;
    endfunction

    assign bus.out_valid = (state == PRESENT);
    assign bus.out_code  = code_q;
    assign pending_o     = pending;

    always_comb begin
        rise      = in & ~in_q;
        take      = (state == PRESENT) && bus.out_ready;
        clr       = take ? (4'b0001 << code_q) : 4'b0000;
        rem       = pending & ~clr;
        // Set wins over clear: a rise re-arms the bit just accepted.
        pending_n = rem | rise;
        state_n   = state;
        code_n    = code_q;
        unique case (state)
            IDLE: begin
                if (pending != 4'b0000) begin
                    code_n  = pick(pending);
                    state_n = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    if (rem != 4'b0000)
                        code_n = pick(rem);
                    else
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // All-ones so lines held high through reset raise no event.
            in_q    <= 4'b1111;
            pending <= 4'b0000;
            overrun <= 1'b0;
            state   <= IDLE;
            code_q  <= 2'd0;
        end else begin
            in_q    <= in;
            pending <= pending_n;
            overrun <= overrun | (|(rise & rem));
            state   <= state_n;
            code_q  <= code_n;
        end
    end
endmodule

// File: tb/tb_event_encoder_4to2.sv
// Scoreboard bench for event_encoder_4to2, both priority orders side by side.
// Reference model predicts presented codes; a negedge monitor compares them.
module tb_event_encoder_4to2;
    logic       clk;
    logic       reset;
    logic [3:0] in;
    logic       rdy;
    logic [3:0] pend_w [2];
    logic       ovr_w  [2];
    logic       val_w  [2];
    logic [1:0] code_w [2];

    int vectors;
    int miscompares;
    bit started;

    event_encoder_4to2_if bus0 ();
    event_encoder_4to2_if bus1 ();

    assign bus0.out_ready = rdy;
    assign bus1.out_ready = rdy;
    assign val_w[0]  = bus0.out_valid;
    assign val_w[1]  = bus1.out_valid;
    assign code_w[0] = bus0.out_code;
    assign code_w[1] = bus1.out_code;

    event_encoder_4to2 #(.LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .in(in), .bus(bus0),
        .pending_o(pend_w[0]), .overrun(ovr_w[0])
    );

    event_encoder_4to2 #(.LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in(in), .bus(bus1),
        .pending_o(pend_w[1]), .overrun(ovr_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: set of pending event indices, index on display (-1 = none).
    logic [3:0] m_pend [2];
    logic [3:0] m_prev [2];
    int         m_pres [2];
    bit         m_ovr  [2];
    int         q0 [$];
    int         q1 [$];

    function automatic int best(input logic [3:0] v, input bit lsb);
        for (int k = 0; k < 4; k++) begin
            int b;
            b = lsb ? k : 3 - k;
            if (v[b]) return b;
        end
        return -1;
    endfunction

    function automatic void push_exp(input int d, input int c);
        if (d == 0) q0.push_back(c);
        else        q1.push_back(c);
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_prev[d] = 4'b1111;
                m_pend[d] = 4'b0000;
                m_pres[d] = -1;
                m_ovr[d]  = 1'b0;
                if (d == 0) q0.delete();
                else        q1.delete();
            end else begin
                logic [3:0] r, left;
                bit acc;
                r    = in & ~m_prev[d];
                acc  = (m_pres[d] >= 0) && rdy;
                left = m_pend[d];
                if (acc) left[m_pres[d]] = 1'b0;
                if ((r & left) != 4'b0000) m_ovr[d] = 1'b1;
                if (m_pres[d] < 0) begin
                    if (m_pend[d] != 4'b0000) begin
                        m_pres[d] = best(m_pend[d], d == 1);
                        push_exp(d, m_pres[d]);
                    end
                end else if (acc) begin
                    m_pres[d] = best(left, d == 1);
                    if (m_pres[d] >= 0) push_exp(d, m_pres[d]);
                end
                m_pend[d] = left | r;
                m_prev[d] = in;
            end
        end
    end

    // Monitor: compare every negedge; pop on each handshake about to complete.
    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                bit ev;
                int exp_c;
                vectors++;
                ev = (m_pres[d] >= 0);
                if (val_w[d] !== ev) begin
                    miscompares++;
                    $display("FAIL valid[%0d] t=%0t got %b want %b", d, $time, val_w[d], ev);
                end
                vectors++;
                if (pend_w[d] !== m_pend[d]) begin
                    miscompares++;
                    $display("FAIL pending[%0d] t=%0t got %b want %b", d, $time, pend_w[d], m_pend[d]);
                end
                vectors++;
                if (ovr_w[d] !== m_ovr[d]) begin
                    miscompares++;
                    $display("FAIL overrun[%0d] t=%0t got %b want %b", d, $time, ovr_w[d], m_ovr[d]);
                end
                if (val_w[d] === 1'b1) begin
                    vectors++;
                    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                        miscompares++;
                        $display("FAIL code[%0d] t=%0t got %0d want none (queue empty)", d, $time, code_w[d]);
                    end else begin
                        exp_c = (d == 0) ? q0[0] : q1[0];
                        if (int'(code_w[d]) != exp_c) begin
                            miscompares++;
                            $display("FAIL code[%0d] t=%0t got %0d want %0d", d, $time, code_w[d], exp_c);
                        end
                        if (rdy === 1'b1 && reset === 1'b0) begin
                            if (d == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Inputs change 2 time units after each rising edge.
    task automatic cyc(input logic [3:0] iv, input logic rv, input logic rst, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
            in    = iv;
            rdy   = rv;
            reset = rst;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        started     = 1'b0;
        reset       = 1'b1;
        in          = 4'b0100;
        rdy         = 1'b0;
        // Line held high through reset, then drop and re-raise.
        cyc(4'b0100, 1'b0, 1'b1, 2);
        cyc(4'b0100, 1'b0, 1'b0, 5);
        cyc(4'b0000, 1'b0, 1'b0, 1);
        cyc(4'b0100, 1'b1, 1'b0, 4);
        // Two same-cycle rises, drained back to back.
        cyc(4'b0000, 1'b1, 1'b0, 2);
        cyc(4'b1010, 1'b1, 1'b0, 5);
        // Stall with a later higher-priority rise.
        cyc(4'b0000, 1'b0, 1'b0, 2);
        cyc(4'b0001, 1'b0, 1'b0, 4);
        cyc(4'b1001, 1'b0, 1'b0, 6);
        cyc(4'b0000, 1'b1, 1'b0, 5);
        // Double pulse while presented.
        cyc(4'b0010, 1'b0, 1'b0, 3);
        cyc(4'b0000, 1'b0, 1'b0, 1);
        cyc(4'b0010, 1'b0, 1'b0, 2);
        cyc(4'b0000, 1'b1, 1'b0, 4);
        // Rise on the bit being accepted.
        cyc(4'b0000, 1'b0, 1'b1, 1);
        cyc(4'b0010, 1'b0, 1'b0, 3);
        cyc(4'b0000, 1'b0, 1'b0, 1);
        cyc(4'b0010, 1'b1, 1'b0, 1);
        cyc(4'b0000, 1'b1, 1'b0, 5);
        // Reset while presenting.
        cyc(4'b1001, 1'b0, 1'b0, 4);
        cyc(4'b1001, 1'b0, 1'b1, 1);
        cyc(4'b0000, 1'b1, 1'b0, 3);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] iv;
            iv = in;
            if ($urandom_range(0, 2) == 0) iv = 4'($urandom);
            cyc(iv, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 79) == 0), 1);
        end
        // Drain and confirm nothing left outstanding.
        cyc(4'b0000, 1'b1, 1'b0, 20);
        @(negedge clk);
        vectors++;
        if (q0.size() + q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d/%0d left want 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/event_encoder_4to2.md
Name: event_encoder_4to2

Overview:
- Sequential 4-to-2 priority encoder with an event-queue front end.
- Detects rising edges on 4 independent input lines, for example debounced buttons or decoder-driven strobes, and latches each edge as a pending event.
- Presents the highest-priority pending event as a 2-bit code on a valid/ready handshake.
- It is the encoding counterpart of the lab's decoder blocks: it turns one-hot activity back into a binary index, one event per handshake.

Parameters:
- LSB_FIRST, default 0: priority order. 0 means bit 3 is highest priority; 1 means bit 0 is highest priority.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in, input, 4: event lines; each line is level, and an event is its 0->1 transition.
- out_ready, input, 1: consumer accepts the presented code this cycle.
- out_code, output, 2: binary index of the presented event.
- out_valid, output, 1: out_code holds a valid event.
- pending_o, output, 4: current pending-event register, for debug and LEDs.
- overrun, output, 1: sticky flag; an event was lost because it merged with an already-pending one.

Behaviour:
- Reset (reset=1 at a clk edge):
  - in_q <= 4'b1111, so lines held high through reset produce no event.
  - pending <= 0, out_valid <= 0, out_code <= 0, overrun <= 0, FSM <= IDLE.
  - Reset mid-handshake discards the presented and all pending events.
- Edge detect:
  - in_q <= in every cycle.
  - rise = in & ~in_q, computed combinationally.
- Pending update each edge: pending <= (pending & ~clr) | rise.
  - clr is the one-hot of out_code when a handshake completes (out_valid & out_ready), else 0.
  - If set and clear hit the same bit in the same cycle, set wins: the bit stays pending.
- Overrun: set when any bit of (rise & pending & ~clr) is 1. Cleared only by reset.
- FSM state IDLE:
  - out_valid=0.
  - If the registered pending != 0: load out_code with the highest-priority pending index per LSB_FIRST, set out_valid <= 1, go to PRESENT.
  - A rise in the current cycle is not visible until the next cycle.
- FSM state PRESENT:
  - out_valid=1; out_code holds stable until accepted.
  - A later higher-priority event does not preempt the presented code.
  - On out_ready=1 at an edge, let rem = pending & ~clr (registered value, excluding this cycle's rise):
    - if rem != 0: load the highest-priority index of rem, stay in PRESENT, out_valid stays 1 (back-to-back, one event per cycle).
    - else: out_valid <= 0, go to IDLE.
  - out_ready while out_valid=0 is ignored.
- Latency:
  - in goes high before edge k; edge k sets pending; edge k+1 asserts out_valid. Two edges from first sample to valid.
- Presented bit:
  - The presented bit remains set in pending until the handshake completes.
  - A new rise on that bit while presented (not in the clear cycle) counts as overrun.
- Priority: a pure function of the pending snapshot at load time; no round-robin.

Test Plan:
1. Reset with in=4'b0100 held, then release: no out_valid for 5 cycles, pending_o=0, overrun=0. Then drop and re-raise in[2]: out_valid=1 with out_code=2 exactly 2 edges later.
2. Same-cycle rises: in 0000->1010 in one cycle with out_ready=1, LSB_FIRST=0. Required sequence: code 3 valid, then code 1 on the next cycle (back-to-back), then out_valid=0. pending_o goes 1010->0010->0000.
3. Stall: pulse in[0] with out_ready=0 for 10 cycles: out_valid=1 and out_code=0 stable throughout. Raise in[3] meanwhile: out_code stays 0 (no preempt). Assert out_ready: next code is 3.
4. Overrun: pulse in[1] twice (0-1-0-1) while it is presented and out_ready=0: overrun=1 and stays 1 after acceptance; only one code-1 event is delivered.
5. Set-beats-clear: accept code 1 in the same cycle in[1] rises again: pending_o[1] stays 1, overrun=0, code 1 is presented again next.
6. Reset mid-PRESENT with pending=1001: one cycle later out_valid=0, pending_o=0, out_code=0. LSB_FIRST=1 rerun of scenario 2 yields order 1 then 3.
